// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD command-line transmit and receive paths:
// frame geometry, CRC7 polynomial, response-latency limit and FSM encoding.
package sd_cmd_pkg;

  localparam int CMD_WIDTH = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;  // x^7 + x^3 + 1
  localparam int NCR_MAX = 64;

  // Bit positions within a 48-bit command/response frame
  localparam int START_BIT = 47;
  localparam int TX_BIT    = 46;
  localparam int END_BIT   = 0;
  // Lowest frame bit covered by the CRC (bits 47..8 are protected)
  localparam int CRC_LAST_BIT = 8;

  // State encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_SHIFT      = 3'd2;
  localparam logic [2:0] ST_DONE       = 3'd3;
  localparam logic [2:0] ST_TIMEOUT    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_WAIT_START = ST_WAIT_START,
    S_SHIFT      = ST_SHIFT,
    S_DONE       = ST_DONE,
    S_TIMEOUT    = ST_TIMEOUT
  } state_e;

  // One serial step of the CRC7 LFSR: feedback is the incoming bit XOR the MSB
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7.sv
// Serial CRC7 generator/checker (x^7+x^3+1, init 0), one bit per enabled cycle.
// Shared by the command transmit and response receive paths.
module crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  // Next CRC value: clear wins over shifting so a new frame always starts from 0
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (shift_en) begin
      crc_d = crc7_step(crc_q, bit_in);
    end
  end

  // CRC register
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/deserializer.sv
// SD CMD-line response receiver: waits for a start bit (bounded by the N_CR
// limit), shifts in a 48-bit response MSB-first, checks CRC7 on the fly and
// flags framing, then holds the word with `complete` until disarmed.
module deserializer
  import sd_cmd_pkg::*;
#(
  parameter int WIDTH   = CMD_WIDTH,  // only 48-bit responses are supported
  parameter int TIMEOUT = NCR_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  output logic [WIDTH-1:0] out,
  output logic             complete,
  output logic             crc_ok,
  output logic             frame_ok,
  output logic             timeout
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int BCW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             complete_q, complete_d;
  logic             crc_ok_q, crc_ok_d;
  logic             frame_ok_q, frame_ok_d;
  logic             timeout_q, timeout_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;

  logic             crc_clear;
  logic             crc_shift;
  logic [6:0]       crc_val;

  // CRC feed control: cleared on arming, fed with the start bit and then with
  // frame bits 46..8 (bit counts 1..39 before the shift); CRC and end bit are not fed.
  always_comb begin
    crc_clear = enable && (state_q == S_IDLE);
    crc_shift = 1'b0;
    if (enable) begin
      if (state_q == S_WAIT_START) begin
        crc_shift = !in;
      end else if (state_q == S_SHIFT) begin
        crc_shift = (bit_cnt_q < BCW'(WIDTH - CRC_LAST_BIT));
      end
    end
  end

  crc7 u_crc7 (
    .clk      (clk),
    .reset    (reset),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .bit_in   (in),
    .crc      (crc_val)
  );

  // Next-state and datapath: dropping enable always returns to IDLE with
  // flags cleared while the last received word stays visible on `out`.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    complete_d = complete_q;
    crc_ok_d   = crc_ok_q;
    frame_ok_d = frame_ok_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;
    bit_cnt_d  = bit_cnt_q;

    if (!enable) begin
      state_d    = S_IDLE;
      complete_d = 1'b0;
      crc_ok_d   = 1'b0;
      frame_ok_d = 1'b0;
      timeout_d  = 1'b0;
      wait_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_WAIT_START;
          complete_d = 1'b0;
          crc_ok_d   = 1'b0;
          frame_ok_d = 1'b0;
          timeout_d  = 1'b0;
          wait_cnt_d = '0;
          bit_cnt_d  = '0;
        end
        S_WAIT_START: begin
          if (!in) begin
            // Start bit: it is frame bit 47 and counts as the first bit
            out_d     = {out_q[WIDTH-2:0], in};
            bit_cnt_d = BCW'(1);
            state_d   = S_SHIFT;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            // A start bit on the last allowed edge is still accepted above
            if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
              state_d   = S_TIMEOUT;
              timeout_d = 1'b1;
            end
          end
        end
        S_SHIFT: begin
          out_d     = {out_q[WIDTH-2:0], in};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(WIDTH - 1)) begin
            // Last bit lands now; the CRC finished feeding 8 bits ago
            state_d    = S_DONE;
            complete_d = 1'b1;
            crc_ok_d   = (crc_val == out_d[7:1]);
            frame_ok_d = !out_d[START_BIT] && !out_d[TX_BIT] && out_d[END_BIT];
          end
        end
        S_DONE, S_TIMEOUT: begin
          // Hold results; the line is ignored until disarmed
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      out_q      <= '0;
      complete_q <= 1'b0;
      crc_ok_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      complete_q <= complete_d;
      crc_ok_q   <= crc_ok_d;
      frame_ok_q <= frame_ok_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign out      = out_q;
  assign complete = complete_q;
  assign crc_ok   = crc_ok_q;
  assign frame_ok = frame_ok_q;
  assign timeout  = timeout_q;

endmodule

// File: doc/deserializer.md
# deserializer

Receive-side counterpart of the SD command-line serializer. Monitors the 1-bit CMD line and waits for a card response start bit. It then shifts in a 48-bit response MSB-first, checks framing and CRC7 on the fly, and presents the parallel word with a `complete` flag. Sits in `src/cmd/communication/` between the CMD pad input and the command control FSM.

## Interface
- `WIDTH`, 48, response length in bits; only 48 is supported (R1/R3/R6/R7).
- `TIMEOUT`, 64, maximum number of cycles in WAIT_START before a timeout is declared (N_CR max).
- `clk`  in  1  sampling clock; CMD line sampled on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `enable`  in  1  level; high = armed/receiving, low = return to IDLE.
- `in`  in  1  serial CMD line; idles high.
- `out`  out  WIDTH  received word; bit 47 = start bit, bit 0 = end bit.
- `complete`  out  1  high once a full frame has been received; held while `enable` stays high.
- `crc_ok`  out  1  CRC7 over bits 47..8 equals bits 7..1; valid when `complete` is high.
- `frame_ok`  out  1  start=0, transmission bit 46=0, end bit 0=1; valid when `complete` is high.
- `timeout`  out  1  no start bit seen within `TIMEOUT` cycles; sticky while `enable` stays high.

## Operation
- States: IDLE, WAIT_START, SHIFT, DONE, TIMEOUT.
- IDLE → WAIT_START when `enable`=1. Entering WAIT_START clears `complete`, `timeout`, `crc_ok`, `frame_ok`, the wait counter, the bit counter and the CRC register. `out` is not cleared.
- WAIT_START:
  - `in`=0 is taken as the start bit: shift it in, set bit count to 1, go to SHIFT.
  - Otherwise increment the wait counter. When the counter reaches `TIMEOUT`, go to TIMEOUT.
- SHIFT:
  - Each cycle, `out` <= {`out`[46:0], `in`} and the bit count increments.
  - The CRC7 engine (polynomial x^7+x^3+1, init 0) is fed with bits 1..40 of the frame, i.e. frame bits 47..8. The start bit is included in the CRC.
  - When the 48th bit is shifted, go to DONE.
- DONE: `complete`=1. `crc_ok` and `frame_ok` are registered in the same cycle that `complete` rises. The block stays in DONE until `enable`=0.
- TIMEOUT: `timeout`=1; `complete` stays 0. The block stays in TIMEOUT until `enable`=0.
- Any state with `enable`=0 → IDLE on the next edge. All flags clear; `out` holds its last value.
- Reset: state=IDLE, `out`=0, `complete`=0, `crc_ok`=0, `frame_ok`=0, `timeout`=0, all counters 0. Reset overrides `enable`.

## Timing
- Edge numbering: edge k=0 is the first WAIT_START edge that samples `in`=0.
- Frame bits 47..0 are sampled on edges 0..47.
- `complete` rises after edge 47 (visible in cycle 48), i.e. 48 cycles after start-bit detection.
- The timeout check starts on the first WAIT_START edge. With the line held high for `TIMEOUT` edges, `timeout` is visible after edge `TIMEOUT`-1.
- A start bit sampled on exactly the last allowed edge (wait count = `TIMEOUT`-1) is accepted; timeout takes precedence only after that.
- Simultaneous `reset` and `enable`: reset wins.
- `enable` deasserted mid-SHIFT aborts the frame. Re-asserting `enable` starts a fresh search with no partial-frame carry-over.
- In DONE or TIMEOUT, `in` is ignored.

## Structure
- Shared package `sd_cmd_pkg`:
  - `CMD_WIDTH`=48, `CRC7_POLY`=7'h09, `NCR_MAX`=64.
  - State encoding (3-bit localparams).
  - Bit-position constants `START_BIT`=47, `TX_BIT`=46, `END_BIT`=0.
- Sub-module `crc7`: serial LFSR with `clk`, `reset`, `clear`, `shift_en`, `bit_in`, `crc[6:0]`. The transmit path reuses the same `crc7`.

## Test plan
- Valid R1: enable, 5 idle-high cycles, then serial 48'h11_0000_0900_67 (CMD17 response, CRC7=0x33) → `complete`=1 at cycle 48 after the start bit, `out`=48'h110000090067, `crc_ok`=1, `frame_ok`=1.
- Corrupted CRC: same frame with bit 3 flipped (48'h11_0000_0900_6F) → `complete`=1, `crc_ok`=0, `frame_ok`=1.
- Bad framing: 48'h51_0000_0900_67 (transmission bit = 1) → `frame_ok`=0. Then 48'h11_0000_0900_66 (end bit 0) → `frame_ok`=0.
- Timeout: enable with `in` held at 1 for 70 cycles → `timeout`=1 after edge 63, `complete`=0. A later start bit is ignored until `enable` is toggled.
- Abort/restart: deassert `enable` after 20 frame bits, re-enable, send the valid R1 → IDLE within 1 cycle with flags cleared, then correct `out`/`crc_ok`=1.
- Reset mid-SHIFT: assert `reset` for 1 cycle at bit 30 → all outputs 0 next cycle, state IDLE.
